// File: rtl/fib_engine.sv
// rtl/fib_engine.sv - iterative Fibonacci engine with wrap or saturate overflow handling
module fib_engine #(
  parameter int WIDTH = 32,
  parameter int NW    = 8,
  parameter int SAT   = 0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             clear,
  input  logic [NW-1:0]    n,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [NW-1:0]    cnt;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ovf_a;
  logic             ovf_b;

  logic [WIDTH:0]   sum;
  logic             carry;
  logic             ovf_next;
  logic [WIDTH-1:0] b_next;

  // Next term of the sequence; the sticky overflow tracks whether b has ever
  // exceeded WIDTH bits, and in saturating mode b pins to all-ones once it has.
  always_comb begin
    sum      = {1'b0, a} + {1'b0, b};
    carry    = sum[WIDTH];
    ovf_next = ovf_a | ovf_b | carry;
    b_next   = sum[WIDTH-1:0];
    if (SAT != 0 && ovf_next) begin
      b_next = '1;
    end
  end

  assign busy = (state != IDLE);

  // Control FSM and datapath: a holds F(k), b holds F(k+1); result takes a
  // (and ovf_a) when the countdown reaches zero, so F(n+1) overflow is ignored.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      a        <= '0;
      b        <= '0;
      ovf_a    <= 1'b0;
      ovf_b    <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !clear) begin
            cnt   <= n;
            a     <= '0;
            b     <= {{(WIDTH-1){1'b0}}, 1'b1};
            ovf_a <= 1'b0;
            ovf_b <= 1'b0;
            state <= CALC;
          end
        end
        CALC: begin
          if (clear) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            result   <= a;
            overflow <= ovf_a;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            a     <= b;
            ovf_a <= ovf_b;
            b     <= b_next;
            ovf_b <= ovf_next;
            cnt   <= cnt - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fib_engine.sv
// tb/tb_fib_engine.sv - directed self-checking bench for fib_engine (wrap and saturate instances)
module tb_fib_engine;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        clear;
  logic [7:0]  n;

  logic        busy0, done0, ovf0;
  logic [31:0] res0;
  logic        busy1, done1, ovf1;
  logic [31:0] res1;

  int          vectors = 0;
  int          miscompares = 0;
  int          lat;
  int          seen;
  longint      fib [0:48];

  always #5 clock = ~clock;

  fib_engine #(.WIDTH(32), .NW(8), .SAT(0)) dut_wrap (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .clear    (clear),
    .n        (n),
    .busy     (busy0),
    .done     (done0),
    .result   (res0),
    .overflow (ovf0)
  );

  fib_engine #(.WIDTH(32), .NW(8), .SAT(1)) dut_sat (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .clear    (clear),
    .n        (n),
    .busy     (busy1),
    .done     (done1),
    .result   (res1),
    .overflow (ovf1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue one start and wait (bounded) for done; lat counts edges after the accepting edge.
  task automatic run(input logic [7:0] nv, output int lt);
    @(negedge clock);
    start = 1'b1;
    n     = nv;
    @(negedge clock);
    start = 1'b0;
    n     = 8'($urandom);
    lt    = -1;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clock);
      if (done0) begin
        lt = k;
        break;
      end
    end
    chk("done_seen", {63'd0, done0}, 64'd1);
  endtask

  initial begin
    fib[0] = 0;
    fib[1] = 1;
    for (int i = 2; i <= 48; i++) fib[i] = fib[i-1] + fib[i-2];

    reset_n = 1'b0;
    start   = 1'b0;
    clear   = 1'b0;
    n       = 8'd0;
    #12;
    chk("rst_busy", {63'd0, busy0}, 64'd0);
    chk("rst_done", {63'd0, done0}, 64'd0);
    chk("rst_result", {32'd0, res0}, 64'd0);
    chk("rst_ovf", {63'd0, ovf0}, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;

    run(8'd10, lat);
    chk("n10_lat", 64'(lat), 64'd11);
    chk("n10_result", {32'd0, res0}, 64'd55);
    chk("n10_ovf", {63'd0, ovf0}, 64'd0);
    chk("n10_sat_result", {32'd0, res1}, 64'd55);
    chk("n10_done_sat", {63'd0, done1}, 64'd1);
    @(negedge clock);
    chk("done_one_cycle", {63'd0, done0}, 64'd0);
    chk("idle_after_done", {63'd0, busy0}, 64'd0);

    run(8'd0, lat);
    chk("n0_lat", 64'(lat), 64'd1);
    chk("n0_result", {32'd0, res0}, 64'd0);
    run(8'd1, lat);
    chk("n1_lat", 64'(lat), 64'd2);
    chk("n1_result", {32'd0, res0}, 64'd1);

    run(8'd3, lat);
    chk("n3_result", {32'd0, res0}, 64'd2);
    start = 1'b1;
    n     = 8'd9;
    @(negedge clock);
    start = 1'b0;
    chk("start_in_done_ignored", {63'd0, busy0}, 64'd0);

    @(negedge clock);
    clear = 1'b1;
    start = 1'b1;
    n     = 8'd4;
    @(negedge clock);
    clear = 1'b0;
    start = 1'b0;
    chk("start_blocked_by_clear", {63'd0, busy0}, 64'd0);

    for (int rep = 0; rep < 50; rep++) begin
      for (int i = 1; i <= 46; i++) begin
        run(8'(i), lat);
        chk("sweep_wrap", {32'd0, res0}, fib[i]);
        chk("sweep_sat", {32'd0, res1}, fib[i]);
      end
    end

    run(8'd47, lat);
    chk("n47_wrap_result", {32'd0, res0}, 64'd2971215073);
    chk("n47_wrap_ovf", {63'd0, ovf0}, 64'd0);
    chk("n47_sat_result", {32'd0, res1}, 64'd2971215073);
    chk("n47_sat_ovf", {63'd0, ovf1}, 64'd0);
    run(8'd48, lat);
    chk("n48_wrap_result", {32'd0, res0}, 64'd512559680);
    chk("n48_wrap_ovf", {63'd0, ovf0}, 64'd1);
    chk("n48_sat_result", {32'd0, res1}, 64'h0000_0000_FFFF_FFFF);
    chk("n48_sat_ovf", {63'd0, ovf1}, 64'd1);

    @(negedge clock);
    start = 1'b1;
    n     = 8'd20;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    start = 1'b1;
    n     = 8'd5;
    @(negedge clock);
    start = 1'b0;
    chk("busy_ignoring_start", {63'd0, busy0}, 64'd1);
    repeat (4) @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    chk("clear_busy", {63'd0, busy0}, 64'd0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (done0 || done1) seen++;
      @(negedge clock);
    end
    chk("clear_no_done", 64'(seen), 64'd0);
    chk("clear_result_held", {32'd0, res0}, 64'd512559680);
    chk("clear_ovf_held", {63'd0, ovf0}, 64'd1);
    run(8'd5, lat);
    chk("after_clear_lat", 64'(lat), 64'd6);
    chk("after_clear_result", {32'd0, res0}, 64'd5);
    chk("after_clear_ovf", {63'd0, ovf0}, 64'd0);

    run(8'd48, lat);
    @(negedge clock);
    start = 1'b1;
    n     = 8'd30;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    chk("pre_reset_busy", {63'd0, busy0}, 64'd1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_busy", {63'd0, busy0}, 64'd0);
    chk("async_rst_done", {63'd0, done0}, 64'd0);
    chk("async_rst_result", {32'd0, res0}, 64'd0);
    chk("async_rst_ovf", {63'd0, ovf0}, 64'd0);
    chk("async_rst_sat_result", {32'd0, res1}, 64'd0);
    chk("async_rst_sat_ovf", {63'd0, ovf1}, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    run(8'd30, lat);
    chk("n30_lat", 64'(lat), 64'd31);
    chk("n30_result", {32'd0, res0}, 64'd832040);
    chk("n30_ovf", {63'd0, ovf0}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
